// File: rtl/xor_cipher_ctrl_if.sv
// Handshake and data bundle between the XOR cipher controller, its serial
// source/sink and the encryption core.
interface xor_cipher_ctrl_if #(
  parameter int MSG_SIZE = 512
);
  localparam int CW = $clog2(MSG_SIZE) + 1;

  logic                iStart;
  logic                iData_bit;
  logic                iData_valid;
  logic                iData_is_key;
  logic                oReady_in;
  logic [MSG_SIZE-1:0] oMessage;
  logic [MSG_SIZE-1:0] oKey;
  logic [CW-1:0]       oMessage_counter;
  logic [CW-1:0]       oKey_counter;
  logic                oCan_encrypt;
  logic                iEncrypt_done;
  logic [MSG_SIZE-1:0] iCiphertext;
  logic                oCipher_bit;
  logic                oCipher_valid;
  logic                iCipher_ready;
  logic                oCore_clear;
  logic                oBusy;
  logic                oDone;
  logic                oError;

  // Controller side
  modport master (
    input  iStart, iData_bit, iData_valid, iData_is_key,
    input  iEncrypt_done, iCiphertext, iCipher_ready,
    output oReady_in, oMessage, oKey, oMessage_counter, oKey_counter,
    output oCan_encrypt, oCipher_bit, oCipher_valid, oCore_clear,
    output oBusy, oDone, oError
  );

  // Environment side: serial source, core and ciphertext sink
  modport slave (
    output iStart, iData_bit, iData_valid, iData_is_key,
    output iEncrypt_done, iCiphertext, iCipher_ready,
    input  oReady_in, oMessage, oKey, oMessage_counter, oKey_counter,
    input  oCan_encrypt, oCipher_bit, oCipher_valid, oCore_clear,
    input  oBusy, oDone, oError
  );
endinterface

// File: rtl/xor_cipher_ctrl.sv
// Sequencer for the XOR encryption core: bit-serial load of message and key,
// timed wait for the core, MSB-first serial ciphertext out, then core clear.
module xor_cipher_ctrl #(
  parameter int MSG_SIZE = 512,
  parameter int TIMEOUT  = 16
) (
  input logic               iClk,
  input logic               iRst,
  xor_cipher_ctrl_if.master bus
);
  localparam int CW = $clog2(MSG_SIZE) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ENCRYPT = 3'd2,
    SEND    = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  state_t              state_r;
  logic [MSG_SIZE-1:0] msgReg_r;
  logic [MSG_SIZE-1:0] keyReg_r;
  logic [MSG_SIZE-1:0] shiftReg_r;
  logic [CW-1:0]       msgCnt_r;
  logic [CW-1:0]       keyCnt_r;
  logic [CW-1:0]       bitCnt_r;
  logic [WW-1:0]       waitCnt_r;
  logic                readyIn_r;
  logic                canEncrypt_r;
  logic                cipherValid_r;
  logic                coreClear_r;
  logic                busy_r;
  logic                error_r;

  logic                msgTake_s;
  logic                keyTake_s;
  logic                msgFullNext_s;
  logic                keyFullNext_s;
  logic                sendLast_s;

  // Load acceptance, post-load fullness and last-bit handshake detection
  always_comb begin
    msgTake_s = 1'b0;
    keyTake_s = 1'b0;
    if (state_r == LOAD && bus.iData_valid) begin
      if (bus.iData_is_key) begin
        keyTake_s = (keyCnt_r != CW'(MSG_SIZE));
      end else begin
        msgTake_s = (msgCnt_r != CW'(MSG_SIZE));
      end
    end else begin
      msgTake_s = 1'b0;
      keyTake_s = 1'b0;
    end
    msgFullNext_s = (msgCnt_r == CW'(MSG_SIZE)) ||
                    (msgTake_s && (msgCnt_r == CW'(MSG_SIZE - 1)));
    keyFullNext_s = (keyCnt_r == CW'(MSG_SIZE)) ||
                    (keyTake_s && (keyCnt_r == CW'(MSG_SIZE - 1)));
    sendLast_s    = (state_r == SEND) && cipherValid_r && bus.iCipher_ready &&
                    (bitCnt_r == CW'(MSG_SIZE - 1));
  end

  // Controller FSM with all registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r       <= IDLE;
      msgReg_r      <= '0;
      keyReg_r      <= '0;
      shiftReg_r    <= '0;
      msgCnt_r      <= '0;
      keyCnt_r      <= '0;
      bitCnt_r      <= '0;
      waitCnt_r     <= '0;
      readyIn_r     <= 1'b0;
      canEncrypt_r  <= 1'b0;
      cipherValid_r <= 1'b0;
      coreClear_r   <= 1'b0;
      busy_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.iStart) begin
            state_r    <= LOAD;
            msgReg_r   <= '0;
            keyReg_r   <= '0;
            shiftReg_r <= '0;
            msgCnt_r   <= '0;
            keyCnt_r   <= '0;
            bitCnt_r   <= '0;
            error_r    <= 1'b0;
            readyIn_r  <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        LOAD: begin
          if (msgTake_s) begin
            msgReg_r <= {msgReg_r[MSG_SIZE-2:0], bus.iData_bit};
            msgCnt_r <= msgCnt_r + CW'(1);
          end
          if (keyTake_s) begin
            keyReg_r <= {keyReg_r[MSG_SIZE-2:0], bus.iData_bit};
            keyCnt_r <= keyCnt_r + CW'(1);
          end
          if (msgFullNext_s && keyFullNext_s) begin
            state_r      <= ENCRYPT;
            readyIn_r    <= 1'b0;
            canEncrypt_r <= 1'b1;
            waitCnt_r    <= '0;
          end
        end
        ENCRYPT: begin
          // A done flag seen on the final wait cycle still beats the timeout
          if (bus.iEncrypt_done) begin
            state_r       <= SEND;
            shiftReg_r    <= bus.iCiphertext;
            canEncrypt_r  <= 1'b0;
            cipherValid_r <= 1'b1;
            bitCnt_r      <= '0;
          end else if (waitCnt_r == WW'(TIMEOUT - 1)) begin
            state_r      <= CLEAR;
            canEncrypt_r <= 1'b0;
            coreClear_r  <= 1'b1;
            error_r      <= 1'b1;
          end else begin
            waitCnt_r <= waitCnt_r + WW'(1);
          end
        end
        SEND: begin
          if (cipherValid_r && bus.iCipher_ready) begin
            shiftReg_r <= {shiftReg_r[MSG_SIZE-2:0], 1'b0};
            bitCnt_r   <= bitCnt_r + CW'(1);
            if (bitCnt_r == CW'(MSG_SIZE - 1)) begin
              state_r       <= CLEAR;
              cipherValid_r <= 1'b0;
              coreClear_r   <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state_r     <= IDLE;
          coreClear_r <= 1'b0;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          readyIn_r     <= 1'b0;
          canEncrypt_r  <= 1'b0;
          cipherValid_r <= 1'b0;
          coreClear_r   <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReady_in        = readyIn_r;
  assign bus.oMessage         = msgReg_r;
  assign bus.oKey             = keyReg_r;
  assign bus.oMessage_counter = msgCnt_r;
  assign bus.oKey_counter     = keyCnt_r;
  assign bus.oCan_encrypt     = canEncrypt_r;
  assign bus.oCipher_bit      = shiftReg_r[MSG_SIZE-1];
  assign bus.oCipher_valid    = cipherValid_r;
  assign bus.oCore_clear      = coreClear_r;
  assign bus.oBusy            = busy_r;
  assign bus.oDone            = sendLast_s;
  assign bus.oError           = error_r;
endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Randomized bench for xor_cipher_ctrl: a transaction-level model predicts
// every output each cycle; directed transactions pin the model with literals.
module tb_xor_cipher_ctrl;
  localparam int MS = 8;
  localparam int TO = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_ENC = 2, P_SEND = 3, P_CLR = 4;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  xor_cipher_ctrl_if #(.MSG_SIZE(MS)) ifc();
  xor_cipher_ctrl #(.MSG_SIZE(MS), .TIMEOUT(TO)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (ifc.master)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checkOn = 1'b0;

  // Behavioural model
  int ph = P_IDLE;
  int mMsg = 0, mKey = 0, mMc = 0, mKc = 0, mWait = 0;
  bit mErr = 1'b0;
  bit mQ[$];

  // Environment configuration and observation totals
  int coreDelay = 1, coreCnt = 0, readyMode = 0, rCnt = 0;
  int hsTot = 0, doneTot = 0, clrTot = 0, encTot = 0;
  logic [7:0] rxWord = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic modelStep();
    if (iRst) begin
      ph = P_IDLE; mMsg = 0; mKey = 0; mMc = 0; mKc = 0; mErr = 1'b0; mWait = 0;
      mQ.delete();
    end else begin
      case (ph)
        P_IDLE: if (ifc.iStart) begin
          ph = P_LOAD; mMsg = 0; mKey = 0; mMc = 0; mKc = 0; mErr = 1'b0;
        end
        P_LOAD: begin
          if (ifc.iData_valid) begin
            if (ifc.iData_is_key) begin
              if (mKc < MS) begin mKey = (mKey * 2 + int'(ifc.iData_bit)) % 256; mKc++; end
            end else begin
              if (mMc < MS) begin mMsg = (mMsg * 2 + int'(ifc.iData_bit)) % 256; mMc++; end
            end
          end
          if (mMc == MS && mKc == MS) begin ph = P_ENC; mWait = 0; end
        end
        P_ENC: begin
          mWait++;
          if (ifc.iEncrypt_done) begin
            for (int i = MS - 1; i >= 0; i--) mQ.push_back(ifc.iCiphertext[i]);
            ph = P_SEND;
          end else if (mWait == TO) begin
            mErr = 1'b1; ph = P_CLR;
          end
        end
        P_SEND: if (ifc.iCipher_ready) begin
          void'(mQ.pop_front());
          if (mQ.size() == 0) ph = P_CLR;
        end
        P_CLR: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  // Core model: latches done after coreDelay enable cycles, cleared by oCore_clear
  task automatic coreStep();
    if (iRst || ifc.oCore_clear) begin
      ifc.iEncrypt_done = 1'b0; coreCnt = 0; ifc.iCiphertext = 8'($urandom);
    end else if (!ifc.iEncrypt_done) begin
      ifc.iCiphertext = 8'($urandom);
      if (ifc.oCan_encrypt) begin
        coreCnt++;
        if (coreCnt >= coreDelay) begin
          ifc.iCiphertext = 8'(mMsg ^ mKey);
          ifc.iEncrypt_done = 1'b1;
        end
      end
    end
  endtask

  task automatic readyStep();
    rCnt++;
    case (readyMode)
      1: ifc.iCipher_ready = (rCnt % 3 == 0);
      2: ifc.iCipher_ready = 1'($urandom_range(0, 1));
      default: ifc.iCipher_ready = 1'b1;
    endcase
  endtask

  task automatic cycleCheck();
    logic expDone, expBit;
    expDone = (ph == P_SEND) && ifc.iCipher_ready && (mQ.size() == 1);
    expBit  = (ph == P_SEND && mQ.size() > 0) ? mQ[0] : 1'b0;
    chk("ready_in",    ifc.oReady_in,        64'(ph == P_LOAD));
    chk("can_encrypt", ifc.oCan_encrypt,     64'(ph == P_ENC));
    chk("cipher_valid",ifc.oCipher_valid,    64'(ph == P_SEND));
    chk("cipher_bit",  ifc.oCipher_bit,      64'(expBit));
    chk("core_clear",  ifc.oCore_clear,      64'(ph == P_CLR));
    chk("busy",        ifc.oBusy,            64'(ph != P_IDLE));
    chk("done",        ifc.oDone,            64'(expDone));
    chk("error",       ifc.oError,           64'(mErr));
    chk("message",     ifc.oMessage,         64'(mMsg));
    chk("key",         ifc.oKey,             64'(mKey));
    chk("msg_counter", ifc.oMessage_counter, 64'(mMc));
    chk("key_counter", ifc.oKey_counter,     64'(mKc));
  endtask

  task automatic tally();
    if (ifc.oCipher_valid && ifc.iCipher_ready && !iRst) begin
      hsTot++;
      rxWord = {rxWord[6:0], ifc.oCipher_bit};
    end
    if (ifc.oDone) doneTot++;
    if (ifc.oCore_clear) clrTot++;
    if (ifc.oCan_encrypt) encTot++;
  endtask

  // order: 0 interleaved (message first), 1 all key bits first, 2 random merge
  task automatic runTxn(input logic [7:0] m, input logic [7:0] k, input int keyExtra,
                        input int order, input int gapPct, input bit holdStart,
                        input int rstAfter);
    int mi, ki, keyN;
    bit takeKey, b, left;
    mi = 0; ki = 0; keyN = MS + keyExtra;
    ifc.iStart = 1'b1;
    tick();
    chk("err_clr_on_start", ifc.oError, 64'(0));
    chk("start_latency", ifc.oReady_in, 64'(1));
    if (!holdStart) ifc.iStart = 1'b0;
    while (mi < MS || ki < keyN) begin
      if ($urandom_range(0, 99) < gapPct) begin
        ifc.iData_valid = 1'b0;
        ifc.iData_bit = 1'($urandom_range(0, 1));
        ifc.iData_is_key = 1'($urandom_range(0, 1));
        tick();
      end
      case (order)
        0: takeKey = (mi >= MS) || (ki < keyN && ki < mi);
        1: takeKey = (ki < keyN);
        default: takeKey = (mi >= MS) || (ki < keyN && $urandom_range(0, 1) == 1);
      endcase
      if (takeKey) begin
        b = (ki < MS) ? k[MS-1-ki] : 1'($urandom_range(0, 1));
        ki++;
      end else begin
        b = m[MS-1-mi];
        mi++;
      end
      ifc.iData_valid = 1'b1;
      ifc.iData_bit = b;
      ifc.iData_is_key = takeKey;
      tick();
    end
    ifc.iData_valid = 1'b0;
    ifc.iData_is_key = 1'($urandom_range(0, 1));
    if (keyExtra == 0 || order == 1) chk("load_to_encrypt_latency", ifc.oCan_encrypt, 64'(1));
    left = 1'b0;
    for (int c = 0; c < 300 && !left; c++) begin
      if (ph == P_IDLE) begin
        left = 1'b1;
      end else begin
        if (holdStart && ph == P_CLR) ifc.iStart = 1'b0;
        if (rstAfter >= 0 && ph == P_SEND && mQ.size() == MS - rstAfter) iRst = 1'b1;
        tick();
        iRst = 1'b0;
      end
    end
    ifc.iStart = 1'b0;
    chk("txn_completes_in_budget", 64'(left), 64'(1));
  endtask

  initial begin
    int hsB, doneB, clrB, encB;
    logic [7:0] rm, rk;
    iRst = 1'b1;
    ifc.iStart = 1'b0; ifc.iData_bit = 1'b0; ifc.iData_valid = 1'b0; ifc.iData_is_key = 1'b0;
    ifc.iEncrypt_done = 1'b0; ifc.iCiphertext = '0; ifc.iCipher_ready = 1'b0;
    fork
      forever begin @(posedge iClk); modelStep(); end
      forever begin @(posedge iClk); #2; coreStep(); end
      forever begin @(posedge iClk); #1; readyStep(); end
      forever begin @(negedge iClk); if (checkOn) begin cycleCheck(); tally(); end end
    join_none
    tick();
    checkOn = 1'b1;
    tick();
    chk("rst_busy", ifc.oBusy, 64'(0));
    chk("rst_message", ifc.oMessage, 64'(0));
    chk("rst_key_counter", ifc.oKey_counter, 64'(0));
    chk("rst_cipher_valid", ifc.oCipher_valid, 64'(0));
    iRst = 1'b0;
    repeat (2) tick();

    // Directed: 0xA5 ^ 0x3C = 0x99, interleaved load
    hsB = hsTot; doneB = doneTot; clrB = clrTot;
    runTxn(8'hA5, 8'h3C, 0, 0, 0, 1'b0, -1);
    chk("model_msg_A5", 64'(mMsg), 64'h A5);
    chk("model_key_3C", 64'(mKey), 64'h 3C);
    chk("stream_99", rxWord, 64'h99);
    chk("handshakes_8", 64'(hsTot - hsB), 64'(8));
    chk("done_once", 64'(doneTot - doneB), 64'(1));
    chk("clear_once", 64'(clrTot - clrB), 64'(1));
    repeat (2) tick();

    // Ready pattern 1,0,0 during SEND
    readyMode = 1; hsB = hsTot; doneB = doneTot;
    runTxn(8'h5A, 8'hF0, 0, 0, 0, 1'b0, -1);
    chk("stream_AA", rxWord, 64'hAA);
    chk("handshakes_8_stall", 64'(hsTot - hsB), 64'(8));
    chk("done_once_stall", 64'(doneTot - doneB), 64'(1));
    readyMode = 0;

    // Ten key bits then eight message bits: key saturates, extras dropped
    runTxn(8'h81, 8'hC3, 2, 1, 0, 1'b0, -1);
    chk("key_sat_model", 64'(mKc), 64'(8));
    chk("key_sat_counter", ifc.oKey_counter, 64'(8));
    chk("key_value_kept", ifc.oKey, 64'hC3);
    chk("stream_42", rxWord, 64'h42);

    // Core never answers: timeout after 16 enable cycles
    coreDelay = 1000; encB = encTot; clrB = clrTot; doneB = doneTot;
    runTxn(8'h12, 8'h34, 0, 0, 0, 1'b0, -1);
    chk("timeout_cycles_16", 64'(encTot - encB), 64'(16));
    chk("timeout_error", ifc.oError, 64'(1));
    chk("timeout_clear", 64'(clrTot - clrB), 64'(1));
    chk("timeout_no_done", 64'(doneTot - doneB), 64'(0));

    // Done on the final wait cycle wins over timeout (also clears prior error)
    coreDelay = 16; doneB = doneTot;
    runTxn(8'hFF, 8'h0F, 0, 0, 0, 1'b0, -1);
    chk("late_done_no_error", ifc.oError, 64'(0));
    chk("late_done_stream", rxWord, 64'hF0);
    chk("late_done_once", 64'(doneTot - doneB), 64'(1));
    coreDelay = 1;

    // Reset in the middle of SEND after three accepted bits
    hsB = hsTot; doneB = doneTot;
    runTxn(8'hC6, 8'h11, 0, 0, 0, 1'b0, 3);
    chk("rst_mid_handshakes", 64'(hsTot - hsB), 64'(3));
    chk("rst_mid_no_done", 64'(doneTot - doneB), 64'(0));
    chk("rst_mid_valid", ifc.oCipher_valid, 64'(0));
    chk("rst_mid_message", ifc.oMessage, 64'(0));
    repeat (4) tick();

    // iStart held high through the transaction
    hsB = hsTot; doneB = doneTot;
    runTxn(8'h3E, 8'h77, 0, 2, 20, 1'b1, -1);
    chk("held_start_stream", rxWord, 64'h49);
    chk("held_start_once", 64'(doneTot - doneB), 64'(1));
    chk("held_start_hs", 64'(hsTot - hsB), 64'(8));
    repeat (3) tick();

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      rm = 8'($urandom); rk = 8'($urandom);
      coreDelay = $urandom_range(1, 18);
      readyMode = $urandom_range(0, 2);
      runTxn(rm, rk, $urandom_range(0, 3), $urandom_range(0, 2), 30,
             1'($urandom_range(0, 1)), -1);
      if (coreDelay <= TO) chk("rand_stream", rxWord, 64'(rm ^ rk));
      else chk("rand_timeout_error", ifc.oError, 64'(1));
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
